// File: rtl/trng_pkg.sv
// Shared constants and pair-FSM encoding for the TRNG bit collector.
package trng_pkg;

    localparam int unsigned TRNG_WORD_W    = 8;
    localparam int unsigned TRNG_RCT_LIMIT = 32;

    typedef enum logic {
        PAIR_EMPTY      = 1'b0,
        PAIR_HAVE_FIRST = 1'b1
    } pair_state_e;

endpackage

// File: rtl/vn_debias.sv
// Von Neumann debiaser: turns sample pairs (0,1)/(1,0) into one unbiased bit, drops equal pairs.
module vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_bit,
    input  logic clear,
    output logic out_valid,
    output logic out_bit
);

    pair_state_e state;
    pair_state_e state_next;
    logic        first_bit;
    logic        first_next;
    logic        out_valid_next;
    logic        out_bit_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PAIR_EMPTY;
            first_bit <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            state     <= state_next;
            first_bit <= first_next;
            out_valid <= out_valid_next;
            out_bit   <= out_bit_next;
        end
    end

    // A clear discards any half-collected pair.
    always_comb begin
        state_next     = state;
        first_next     = first_bit;
        out_valid_next = 1'b0;
        out_bit_next   = out_bit;
        if (clear) begin
            state_next = PAIR_EMPTY;
        end else if (in_valid) begin
            case (state)
                PAIR_EMPTY: begin
                    first_next = in_bit;
                    state_next = PAIR_HAVE_FIRST;
                end
                PAIR_HAVE_FIRST: begin
                    if (first_bit != in_bit) begin
                        out_valid_next = 1'b1;
                        out_bit_next   = first_bit;
                    end
                    state_next = PAIR_EMPTY;
                end
                default: state_next = PAIR_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/trng_collector.sv
// Synchronizes the ring-oscillator sample, health-checks it, debiases it and packs words.
module trng_collector
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH     = TRNG_WORD_W,
    parameter int unsigned RCT_LIMIT = TRNG_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             raw_bit,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             health_fail,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);

    logic             sync1;
    logic             s;
    logic             rct_armed;
    logic             prev;
    logic [RUN_W-1:0] run;
    logic             db_valid;
    logic             db_bit;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             transfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            s     <= sync1;
        end
    end

    // Repetition-count test; the first enabled sample after a pause restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            rct_armed   <= 1'b0;
            prev        <= 1'b0;
            run         <= '0;
            health_fail <= 1'b0;
        end else begin
            if (!enable) begin
                rct_armed <= 1'b0;
            end else if (!rct_armed) begin
                rct_armed <= 1'b1;
                run       <= RUN_W'(1);
                prev      <= s;
            end else begin
                prev <= s;
                if (s == prev) begin
                    if (run != RUN_W'(RCT_LIMIT)) begin
                        run <= run + RUN_W'(1);
                    end
                end else begin
                    run <= RUN_W'(1);
                end
            end
            if (run == RUN_W'(RCT_LIMIT)) begin
                health_fail <= 1'b1;
            end
        end
    end

    vn_debias u_debias (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (enable),
        .in_bit    (s),
        .clear     (!enable),
        .out_valid (db_valid),
        .out_bit   (db_bit)
    );

    assign transfer = (cnt == CNT_W'(WIDTH)) && !health_fail && (!valid || ready);

    // A bit arriving alongside a transfer starts the next word instead of being dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else if (transfer) begin
            data_out <= sr;
            valid    <= 1'b1;
            if (db_valid) begin
                sr  <= {sr[WIDTH-2:0], db_bit};
                cnt <= CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (db_valid) begin
                if (cnt == CNT_W'(WIDTH)) begin
                    overrun <= 1'b1;
                end else begin
                    sr  <= {sr[WIDTH-2:0], db_bit};
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector with an expected-word queue checked by a separate monitor.
module tb_trng_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       raw_bit;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       health_fail;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       en_d1;
    logic       en_d2;
    logic [7:0] hold_val;
    bit         have_hold = 1'b0;

    always #5 clk = ~clk;

    trng_collector #(.WIDTH(8), .RCT_LIMIT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .raw_bit     (raw_bit),
        .data_out    (data_out),
        .valid       (valid),
        .ready       (ready),
        .health_fail (health_fail),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One synchronized sample: raw goes in now, its enable is applied when it reaches s.
    task automatic step(input logic r, input logic e);
        @(posedge clk);
        #2;
        raw_bit = r;
        enable  = en_d2;
        en_d2   = en_d1;
        en_d1   = e;
    endtask

    task automatic pair(input logic a, input logic b);
        step(a, 1'b1);
        step(b, 1'b1);
    endtask

    task automatic flush(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) pair(w[i], !w[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst     = 1'b1;
        enable  = 1'b0;
        en_d1   = 1'b0;
        en_d2   = 1'b0;
        raw_bit = 1'b0;
        @(posedge clk);
        #2;
        rst       = 1'b0;
        have_hold = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_health"}, 32'(health_fail), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: every presented word must match the head of the queue and stay put while stalled.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected no word", data_out);
            end else if (ready) begin
                check("word", 32'(data_out), 32'(exp_q.pop_front()));
                have_hold = 1'b0;
            end else if (have_hold) begin
                check("hold", 32'(data_out), 32'(hold_val));
            end else begin
                hold_val  = data_out;
                have_hold = 1'b1;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        raw_bit = 1'b0;
        ready   = 1'b1;
        en_d1   = 1'b0;
        en_d2   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle_outputs("reset");

        // all (1,0) pairs then all (0,1) pairs
        exp_q.push_back(8'hFF);
        send_word(8'hFF);
        exp_q.push_back(8'h00);
        send_word(8'h00);
        flush(4);
        wait_drain("t1");
        check("t1_health", 32'(health_fail), 32'h0);
        check("t1_overrun", 32'(overrun), 32'h0);

        // alternating bits, then the same word with equal pairs interleaved
        exp_q.push_back(8'hAA);
        send_word(8'hAA);
        exp_q.push_back(8'hAA);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hAA;
            pair(w[i], !w[i]);
            pair(1'(i % 2), 1'(i % 2));
        end
        flush(4);
        wait_drain("t2");

        // back-pressure: one word held, one parked in sr, third word dropped
        ready = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        repeat (24) pair(1'b1, 1'b0);
        flush(4);
        check("t3_valid", 32'(valid), 32'h1);
        check("t3_overrun", 32'(overrun), 32'h1);
        check("t3_pending", 32'(exp_q.size()), 32'h2);
        ready = 1'b1;
        wait_drain("t3");
        flush(2);
        check("t3_valid_low", 32'(valid), 32'h0);
        check("t3_overrun_sticky", 32'(overrun), 32'h1);

        // repetition count: 32nd identical sample trips health_fail one edge later
        do_reset();
        check_idle_outputs("t4_reset");
        repeat (4) step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1);
            if (i == 34) check("t4_health_before", 32'(health_fail), 32'h0);
            if (i == 35) check("t4_health_trip", 32'(health_fail), 32'h1);
        end
        send_word(8'hFF);
        flush(6);
        check("t4_no_valid", 32'(valid), 32'h0);
        check("t4_health_sticky", 32'(health_fail), 32'h1);
        do_reset();
        check("t4_health_cleared", 32'(health_fail), 32'h0);

        // enable dropped mid-pair discards the half pair only
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hA5;
            if (i == 4) begin
                step(1'b1, 1'b1);
                step(1'b0, 1'b0);
            end
            pair(w[i], !w[i]);
        end
        flush(4);
        wait_drain("t5");

        // reset after a partial word: next word contains post-reset bits only
        repeat (5) pair(1'b1, 1'b0);
        flush(3);
        do_reset();
        check_idle_outputs("t6_reset");
        exp_q.push_back(8'h3C);
        send_word(8'h3C);
        flush(4);
        wait_drain("t6");
        flush(2);
        check("t6_valid_low", 32'(valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
